// File: rtl/apb_slave_mem_resp.sv
// APB3/APB4 completer backed by a flop-array memory, with wait states and error response.
// Optional byte-strobe writes: define APB_SLV_PSTRB_EN to add the pstrb port.
module apb_slave_mem_resp #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WAIT_W    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    input  logic [WAIT_W-1:0] cfg_wait,
    input  logic              err_inject,
    output logic              proto_err
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]     a_idx;
    logic              a_write;
    logic              a_err;
    logic [DATA_W-1:0] a_wdata;
    logic [NB-1:0]     a_strb;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] widx;
    logic [IW-1:0]     idx_in;
    logic              err_in;
    logic              setup;
    logic              access;
    logic [NB-1:0]     strb_in;

`ifdef APB_SLV_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    assign off    = paddr - BASE_ADDR;
    assign widx   = off >> OFF;
    assign idx_in = widx[IW-1:0];
    assign setup  = psel & ~penable;
    assign access = psel & penable;

    // Underflow below BASE_ADDR wraps off, so it is caught separately.
    assign err_in = err_inject
                  | (paddr < BASE_ADDR)
                  | (widx >= ADDR_W'(DEPTH))
                  | ((paddr & ADDR_W'(NB - 1)) != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            proto_err <= 1'b0;
            a_idx     <= '0;
            a_write   <= 1'b0;
            a_err     <= 1'b0;
            a_wdata   <= '0;
            a_strb    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (setup) begin
                        a_idx   <= idx_in;
                        a_write <= pwrite;
                        a_wdata <= pwdata;
                        a_strb  <= strb_in;
                        a_err   <= err_in;
                        if (cfg_wait == '0) begin
                            pready  <= 1'b1;
                            pslverr <= err_in;
                            prdata  <= (pwrite || err_in) ? '0 : mem[idx_in];
                            state   <= S_RESP;
                        end else begin
                            cnt   <= cfg_wait - WAIT_W'(1);
                            state <= S_WAIT;
                        end
                    end else if (access) begin
                        proto_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!access) begin
                        proto_err <= 1'b1;
                        pready    <= 1'b0;
                        pslverr   <= 1'b0;
                        prdata    <= '0;
                        state     <= S_IDLE;
                    end else if (cnt == '0) begin
                        pready  <= 1'b1;
                        pslverr <= a_err;
                        prdata  <= (a_write || a_err) ? '0 : mem[a_idx];
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    if (access) begin
                        if (a_write && !a_err) begin
                            for (int b = 0; b < NB; b++) begin
                                if (a_strb[b]) begin
                                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
                                end
                            end
                        end
                    end else begin
                        proto_err <= 1'b1;
                    end
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem_resp.sv
// Scoreboard bench for apb_slave_mem_resp: driver pushes expected responses,
// a negedge monitor pops and checks them when pready completes a transfer.
module tb_apb_slave_mem_resp;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  cfg_wait = '0;
    logic        err_inject = 1'b0;
    logic        proto_err;

    apb_slave_mem_resp dut (
        .clk(clk),
        .resetn(resetn),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready),
        .prdata(prdata),
        .pslverr(pslverr),
        .cfg_wait(cfg_wait),
        .err_inject(err_inject),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
        logic [31:0] addr;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          waitcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: count access-phase stall cycles, compare on completion.
    always @(negedge clk) begin
        if (resetn && psel && penable) begin
            if (!pready) begin
                waitcnt++;
            end else if (expq.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
                waitcnt = 0;
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk($sformatf("prdata@%h", e.addr), prdata, e.rdata);
                chk($sformatf("pslverr@%h", e.addr), 32'(pslverr), 32'(e.err));
                chk($sformatf("waits@%h", e.addr), waitcnt, e.waits);
                waitcnt = 0;
            end
        end else begin
            waitcnt = 0;
        end
    end

    function automatic exp_t predict(input logic [31:0] a, input logic w,
                                     input logic [31:0] d, input int wt,
                                     input logic inj, input logic [3:0] s);
        exp_t e;
        logic err;
        int idx;
        logic [3:0] es;
`ifdef APB_SLV_PSTRB_EN
        es = s;
`else
        es = 4'hF;
`endif
        err = inj || (a >= DEPTH * 4) || (a % 4 != 0);
        idx = int'(a / 4) % DEPTH;
        e.addr = a;
        e.err = err;
        e.waits = wt;
        e.rdata = (!w && !err) ? model[idx] : 32'h0;
        if (w && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (es[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        return e;
    endfunction

    // Entered and left at posedge+1; consecutive calls are back-to-back.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int wt, input logic inj, input logic [3:0] s);
        int n;
        expq.push_back(predict(a, w, d, wt, inj, s));
        psel = 1'b1;
        penable = 1'b0;
        pwrite = w;
        paddr = a;
        pwdata = d;
        cfg_wait = 4'(wt);
        err_inject = inj;
        pstrb = s;
        @(posedge clk);
        #1;
        penable = 1'b1;
        err_inject = $urandom_range(0, 1) == 1;
        cfg_wait = 4'($urandom);
        paddr = $urandom;
        pwdata = $urandom;
        n = 0;
        forever begin
            @(negedge clk);
            if (pready) break;
            n++;
            if (n > 40) begin
                chk("pready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        err_inject = 1'b0;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #12;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_pready", 32'(pready), 32'd0);
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_proto_err", 32'(proto_err), 32'd0);

        xfer(32'h00, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        xfer(32'h10, 1'b1, 32'hDEADBEEF, 3, 1'b0, 4'hF);
        xfer(32'h10, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        xfer(32'h100, 1'b0, 32'h0, 1, 1'b0, 4'hF);
        xfer(32'h00, 1'b1, 32'h0BADF00D, 0, 1'b0, 4'hF);
        xfer(32'h02, 1'b1, 32'h12345678, 2, 1'b0, 4'hF);
        xfer(32'h00, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        xfer(32'h04, 1'b1, 32'hCAFEBABE, 0, 1'b1, 4'hF);
        xfer(32'h04, 1'b0, 32'h0, 1, 1'b0, 4'hF);

        c0 = cyc;
        xfer(32'h00, 1'b1, 32'h11111111, 0, 1'b0, 4'hF);
        xfer(32'h04, 1'b1, 32'h22222222, 0, 1'b0, 4'hF);
        chk("b2b_cycles", cyc - c0, 32'd4);
        xfer(32'h00, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        xfer(32'h04, 1'b0, 32'h0, 0, 1'b0, 4'hF);

`ifdef APB_SLV_PSTRB_EN
        xfer(32'h40, 1'b1, 32'hAABBCCDD, 0, 1'b0, 4'hF);
        xfer(32'h40, 1'b1, 32'h11223344, 1, 1'b0, 4'b0101);
        xfer(32'h40, 1'b0, 32'h0, 0, 1'b0, 4'h0);
        chk("strobe_merge_model", model[16], 32'hAA22CC44);
        xfer(32'h40, 1'b1, 32'h55555555, 0, 1'b0, 4'h0);
        xfer(32'h40, 1'b0, 32'h0, 0, 1'b0, 4'h0);
`endif

        chk("proto_err_clean", 32'(proto_err), 32'd0);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h20;
        pwdata = 32'h99999999;
        cfg_wait = 4'd5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_proto_err", 32'(proto_err), 32'd1);
        chk("abort_pready", 32'(pready), 32'd0);
        xfer(32'h20, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        chk("proto_err_sticky", 32'(proto_err), 32'd1);

        expq.push_back(predict(32'h10, 1'b0, 32'h0, 0, 1'b0, 4'hF));
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 32'h10;
        cfg_wait = 4'd0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        #1;
        chk("async_rst_pready", 32'(pready), 32'd0);
        chk("async_rst_prdata", prdata, 32'd0);
        chk("async_rst_pslverr", 32'(pslverr), 32'd0);
        chk("async_rst_proto_err", 32'(proto_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(32'h10, 1'b0, 32'h0, 0, 1'b0, 4'hF);
        xfer(32'h04, 1'b0, 32'h0, 2, 1'b0, 4'hF);

        for (int t = 0; t < 80; t++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else a = 32'($urandom_range(DEPTH * 4, 1023));
            xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 7) == 0, 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            xfer(32'(i * 4), 1'b0, 32'h0, 0, 1'b0, 4'hF);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
